lane_traffic_engine: RTL and testbench
======================================

Name: lane_traffic_engine

Overview:
Parametrised successor to the fixed eight-car controller. It owns the x-positions of N_LANES cars, one car per lane. On each frame tick it advances them with per-lane direction and speed, scaled by a difficulty level. After every frame it runs a sequential lane-by-lane collision scan against the frog's bounding box. It sits between vga_control (frame tick source) and player_control / color_generation (consumers of car_x and hit).

Parameters:
N_LANES, 8, number of lanes and cars; lane i uses index bits LW = $clog2(N_LANES)
X_W, 10, width of every coordinate
H_ACTIVE, 640, visible width; car x is kept in [0, H_ACTIVE-1]
CAR_W, 32, car width in pixels
LANE_Y0, 64, top y of lane 0
LANE_PITCH, 48, y distance between lane tops
LANE_H, 32, car height
PLAYER_SZ, 32, frog square size
BASE_PERIOD, 4, frame ticks per move step at level 0

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
run  in  1  1 = game running; 0 = freeze positions and ignore ticks
level  in  4  difficulty level, sampled at an accepted tick
player_x  in  X_W  frog left x
player_y  in  X_W  frog top y
car_x  out  N_LANES*X_W  packed car x; lane i occupies bits [i*X_W +: X_W]
hit  out  1  one-cycle pulse: frog overlaps a car
hit_lane  out  LW  lowest overlapping lane index, valid with hit, held afterwards
busy  out  1  high while the FSM is not in IDLE
overrun  out  1  sticky: a frame_tick arrived while busy

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values:
  - car_x lane i = i*(H_ACTIVE/N_LANES)
  - divider = 0, state = IDLE
  - hit = 0, hit_lane = 0, busy = 0, overrun = 0
- Lane properties:
  - Direction: even lanes move right (+), odd lanes move left (−).
  - Step for lane i = 1 + (i mod 3) pixels per move.
  - Lane y top = LANE_Y0 + i*LANE_PITCH.
- Move period: P = max(1, BASE_PERIOD − level), computed from the level sampled at the accepted tick.
- FSM states: IDLE, MOVE, CHECK, DONE.
- IDLE:
  - A tick is accepted when frame_tick=1 and run=1.
  - On an accepted tick, divider increments.
  - If divider+1 >= P: divider clears, next state is MOVE with lane ptr=0.
  - Otherwise: next state is CHECK with ptr=0.
  - run=0: ticks are ignored and the divider holds.
- MOVE:
  - Updates one lane per cycle, ptr 0..N_LANES−1, then goes to CHECK with ptr=0.
  - Right wrap: x+step >= H_ACTIVE gives x+step−H_ACTIVE.
  - Left wrap: x < step gives x+H_ACTIVE−step.
  - Arithmetic is done in X_W+1 bits.
- CHECK:
  - player_x and player_y are latched on entry.
  - One lane is compared per cycle.
  - Overlap test: px < cx+CAR_W AND cx < px+PLAYER_SZ AND py < ly+LANE_H AND ly < py+PLAYER_SZ, evaluated in X_W+1 bits.
  - The first overlapping lane is recorded.
  - Cars split across the wrap edge are tested only at their stored x.
- DONE (1 cycle):
  - Pulse hit if any lane overlapped; update hit_lane.
  - Return to IDLE.
- Latency, counted from the tick cycle 0:
  - With a move: MOVE on cycles 1..N, CHECK on N+1..2N, hit on cycle 2N+1.
  - Without a move: CHECK on 1..N, hit on cycle N+1.
- Tick while busy: ignored; divider unaffected; overrun set to 1 until RST.
- run deasserted mid-sequence: the current sequence completes.
- RST mid-sequence: immediate return to reset values; a partial MOVE is discarded.
- busy equals (state != IDLE).

Decomposition:
- Lane geometry defaults (LANE_Y0, LANE_PITCH, LANE_H, CAR_W, H_ACTIVE, PLAYER_SZ) go in the shared constants.v.
- FSM state encoding is a localparam set, also in constants.v.
- One natural sub-module: lane_stepper, combinational. Inputs: x, step, dir. Output: wrapped next x.
- The engine holds the car_x register array, the FSM, the divider and the overlap compare.

Test Plan:
- RST pulse mid-MOVE → car_x = {560,480,400,320,240,160,80,0} (lane 7..0), hit=0, busy=0, overrun=0 asynchronously.
- level=0, run=1, player parked at (600,0), four ticks 100 cycles apart → after the 4th tick: lane0=1, lane1=78, lane2=163; the first three ticks leave positions unchanged.
- level=3 (P=1), one tick per frame:
  - Lane0 after 640 ticks = 0 (right wrap passes through 639).
  - Lane1 after 41 ticks = 638 (left wrap).
- run=1, level=0, player at (0,64), one tick → hit pulses on cycle 9 for exactly one cycle, hit_lane=0, busy low from cycle 10.
- level=9 → P saturates at 1; every tick moves. run=0 with ticks → car_x frozen, busy stays 0.
- Tick at cycle 0, second tick at cycle 3 → overrun=1 and stays 1; only one move occurs; divider counts one tick.

Source files
------------

// File: rtl/lane_traffic_engine_pkg.sv
// Shared constants, FSM state encoding and the move-period helper for the lane traffic engine.
package lane_traffic_engine_pkg;

  localparam int DEF_N_LANES     = 8;
  localparam int DEF_X_W         = 10;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_CAR_W       = 32;
  localparam int DEF_LANE_Y0     = 64;
  localparam int DEF_LANE_PITCH  = 48;
  localparam int DEF_LANE_H      = 32;
  localparam int DEF_PLAYER_SZ   = 32;
  localparam int DEF_BASE_PERIOD = 4;
  localparam int DIV_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Frame ticks per move step: max(1, base - level), never zero.
  function automatic logic [DIV_W-1:0] move_period(input logic [3:0] level, input int base);
    if (int'(level) >= base - 1) return DIV_W'(1);
    else return DIV_W'(base - int'(level));
  endfunction

endpackage

// File: rtl/lane_traffic_engine_if.sv
// Bundle between the frame/player side and the lane traffic engine.
interface lane_traffic_engine_if #(
  parameter int N_LANES = 8,
  parameter int X_W     = 10
);
  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  // frame_tick is a one-cycle pulse with no ready: it is taken only while busy
  // is low and run is high; a pulse seen while busy is dropped and sets overrun.
  logic                   frame_tick;
  logic                   run;
  logic [3:0]             level;
  logic [X_W-1:0]         player_x;
  logic [X_W-1:0]         player_y;
  logic [N_LANES*X_W-1:0] car_x;
  logic                   hit;
  logic [LW-1:0]          hit_lane;
  logic                   busy;
  logic                   overrun;

  modport master (
    output frame_tick, run, level, player_x, player_y,
    input  car_x, hit, hit_lane, busy, overrun
  );

  modport slave (
    input  frame_tick, run, level, player_x, player_y,
    output car_x, hit, hit_lane, busy, overrun
  );

endinterface

// File: rtl/lane_traffic_engine_lane_stepper.sv
// Combinational one-step car mover with wrap-around at the visible width.
module lane_traffic_engine_lane_stepper #(
  parameter int X_W      = 10,
  parameter int H_ACTIVE = 640
) (
  input  logic [X_W-1:0] x_i,
  input  logic [X_W-1:0] step_i,
  input  logic           dir_i,   // 0 = right, 1 = left
  output logic [X_W-1:0] x_o
);
  localparam int CW = X_W + 1;

  logic [CW-1:0] x_w;
  logic [CW-1:0] s_w;
  logic [CW-1:0] sum_w;

  always_comb begin
    x_w   = CW'(x_i);
    s_w   = CW'(step_i);
    sum_w = '0;
    if (!dir_i) begin
      sum_w = x_w + s_w;
      if (sum_w >= CW'(H_ACTIVE)) sum_w = sum_w - CW'(H_ACTIVE);
    end else if (x_w < s_w) begin
      sum_w = x_w + CW'(H_ACTIVE) - s_w;
    end else begin
      sum_w = x_w - s_w;
    end
    x_o = sum_w[X_W-1:0];
  end

endmodule

// File: rtl/lane_traffic_engine.sv
// Lane traffic engine: per-frame car movement followed by a lane-by-lane
// collision scan against the frog's bounding box.
module lane_traffic_engine
  import lane_traffic_engine_pkg::*;
#(
  parameter int N_LANES     = DEF_N_LANES,
  parameter int X_W         = DEF_X_W,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int CAR_W       = DEF_CAR_W,
  parameter int LANE_Y0     = DEF_LANE_Y0,
  parameter int LANE_PITCH  = DEF_LANE_PITCH,
  parameter int LANE_H      = DEF_LANE_H,
  parameter int PLAYER_SZ   = DEF_PLAYER_SZ,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD
) (
  input  logic                CLK,
  input  logic                RST,
  lane_traffic_engine_if.slave bus,
  output state_e              dbg_state_o
);
  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int CW = X_W + 1;

  state_e              state_q, state_d;
  logic [LW-1:0]       ptr_q, ptr_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [X_W-1:0]      car_q [N_LANES];
  logic [X_W-1:0]      car_d [N_LANES];
  logic [X_W-1:0]      px_q, px_d, py_q, py_d;
  logic                found_q, found_d;
  logic [LW-1:0]       flane_q, flane_d;
  logic                hit_q, hit_d;
  logic [LW-1:0]       hit_lane_q, hit_lane_d;
  logic                ovr_q, ovr_d;

  logic                tick_ok;
  logic                last_lane;
  logic                overlap;
  logic [DIV_W-1:0]    period;
  logic [X_W-1:0]      cur_x, step, next_x;
  logic [CW-1:0]       lane_y;
  logic [N_LANES*X_W-1:0] car_flat;

  lane_traffic_engine_lane_stepper #(
    .X_W      (X_W),
    .H_ACTIVE (H_ACTIVE)
  ) u_stepper (
    .x_i    (cur_x),
    .step_i (step),
    .dir_i  (ptr_q[0]),
    .x_o    (next_x)
  );

  always_comb begin
    tick_ok   = bus.frame_tick && bus.run;
    last_lane = (ptr_q == LW'(N_LANES - 1));
    period    = move_period(bus.level, BASE_PERIOD);
    cur_x     = car_q[ptr_q];
    step      = X_W'(32'(ptr_q) % 3 + 1);
    lane_y    = CW'(LANE_Y0 + 32'(ptr_q) * LANE_PITCH);
    // Split cars are tested only at their stored x; no wrap-aware compare.
    overlap   = (CW'(px_q) < CW'(cur_x) + CW'(CAR_W)) &&
                (CW'(cur_x) < CW'(px_q) + CW'(PLAYER_SZ)) &&
                (CW'(py_q) < lane_y + CW'(LANE_H)) &&
                (lane_y < CW'(py_q) + CW'(PLAYER_SZ));
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    div_d      = div_q;
    car_d      = car_q;
    px_d       = px_q;
    py_d       = py_q;
    found_d    = found_q;
    flane_d    = flane_q;
    hit_d      = 1'b0;
    hit_lane_d = hit_lane_q;
    ovr_d      = ovr_q | (bus.frame_tick && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (tick_ok) begin
          ptr_d   = '0;
          found_d = 1'b0;
          flane_d = '0;
          if ((div_q + DIV_W'(1)) >= period) begin
            div_d   = '0;
            state_d = ST_MOVE;
          end else begin
            div_d   = div_q + DIV_W'(1);
            state_d = ST_CHECK;
            px_d    = bus.player_x;
            py_d    = bus.player_y;
          end
        end
      end
      ST_MOVE: begin
        car_d[ptr_q] = next_x;
        if (last_lane) begin
          ptr_d   = '0;
          state_d = ST_CHECK;
          px_d    = bus.player_x;
          py_d    = bus.player_y;
        end else begin
          ptr_d = ptr_q + LW'(1);
        end
      end
      ST_CHECK: begin
        if (overlap && !found_q) begin
          found_d = 1'b1;
          flane_d = ptr_q;
        end
        if (last_lane) begin
          state_d = ST_DONE;
          hit_d   = found_d;
          if (found_d) hit_lane_d = flane_d;
        end else begin
          ptr_d = ptr_q + LW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      div_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      found_q    <= 1'b0;
      flane_q    <= '0;
      hit_q      <= 1'b0;
      hit_lane_q <= '0;
      ovr_q      <= 1'b0;
      for (int i = 0; i < N_LANES; i++) car_q[i] <= X_W'(i * (H_ACTIVE / N_LANES));
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      div_q      <= div_d;
      px_q       <= px_d;
      py_q       <= py_d;
      found_q    <= found_d;
      flane_q    <= flane_d;
      hit_q      <= hit_d;
      hit_lane_q <= hit_lane_d;
      ovr_q      <= ovr_d;
      for (int i = 0; i < N_LANES; i++) car_q[i] <= car_d[i];
    end
  end

  always_comb begin
    car_flat = '0;
    for (int i = 0; i < N_LANES; i++) car_flat[i*X_W +: X_W] = car_q[i];
  end

  assign bus.car_x    = car_flat;
  assign bus.hit      = hit_q;
  assign bus.hit_lane = hit_lane_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.overrun  = ovr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lane_traffic_engine.sv
// Bench for lane_traffic_engine: frame-level model plus directed literal checks.
module tb_lane_traffic_engine;
  import lane_traffic_engine_pkg::*;

  localparam int N  = 8;
  localparam int XW = 10;
  localparam int HA = 640;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     cyc;
  int     checks;
  int     failures;
  bit     chk_en;

  lane_traffic_engine_if #(.N_LANES(N), .X_W(XW)) bus ();

  lane_traffic_engine dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- frame-level model ----------------
  int exp_car  [N];
  int pend_car [N];
  int m_div;
  int t0;
  int seq_len;
  bit pend_hit;
  int pend_hl;
  int hl_held;
  bit ovr_set;
  int ovr_from;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_car[i]  = i * (HA / N);
      pend_car[i] = i * (HA / N);
    end
    m_div    = 0;
    t0       = -1000;
    seq_len  = 0;
    pend_hit = 1'b0;
    pend_hl  = 0;
    hl_held  = 0;
    ovr_set  = 1'b0;
    ovr_from = 0;
  endtask

  function automatic bit boxes_touch(int px, int py, int cx, int ly);
    return (px < cx + 32) && (cx < px + 32) && (py < ly + 32) && (ly < py + 32);
  endfunction

  // Called on the cycle the tick is presented; works on whole frames only.
  task automatic model_tick();
    int p;
    if (cyc <= t0 + seq_len) begin
      if (!ovr_set) begin
        ovr_set  = 1'b1;
        ovr_from = cyc + 1;
      end
      return;
    end
    if (!bus.run) return;
    m_div++;
    p = (int'(bus.level) >= 4) ? 1 : 4 - int'(bus.level);
    for (int i = 0; i < N; i++) pend_car[i] = exp_car[i];
    if (m_div >= p) begin
      m_div = 0;
      for (int i = 0; i < N; i++) begin
        int delta;
        delta       = ((i % 2) ? -1 : 1) * (1 + i % 3);
        pend_car[i] = ((exp_car[i] + delta) % HA + HA) % HA;
      end
      seq_len = 2 * N + 1;
    end else begin
      seq_len = N + 1;
    end
    pend_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pend_hit && boxes_touch(int'(bus.player_x), int'(bus.player_y), pend_car[i], 64 + 48 * i)) begin
        pend_hit = 1'b1;
        pend_hl  = i;
      end
    end
    t0 = cyc;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int car_lane(int i);
    return int'(bus.car_x[i*XW +: XW]);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      bit eb;
      bit eh;
      eb = (cyc >= t0 + 1) && (cyc <= t0 + seq_len);
      eh = (cyc == t0 + seq_len) && pend_hit;
      if (cyc == t0 + seq_len) begin
        for (int i = 0; i < N; i++) exp_car[i] = pend_car[i];
        if (pend_hit) hl_held = pend_hl;
      end
      check("busy", bus.busy, eb);
      check("hit", bus.hit, eh);
      check("hit_lane", bus.hit_lane, hl_held);
      check("overrun", bus.overrun, ovr_set && (cyc >= ovr_from));
      if (!eb) begin
        for (int i = 0; i < N; i++) check("car_x", car_lane(i), exp_car[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    model_tick();
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic set_player(input int x, input int y);
    bus.player_x = XW'(x);
    bus.player_y = XW'(y);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hit_t0;
    int k;
    cyc            = 0;
    checks         = 0;
    failures       = 0;
    chk_en         = 1'b0;
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.run        = 1'b1;
    bus.level      = 4'd0;
    set_player(600, 0);
    model_reset();
    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) check("reset_car_x", car_lane(i), 80 * i);
    check("reset_busy", bus.busy, 0);
    check("reset_hit", bus.hit, 0);
    check("reset_hit_lane", bus.hit_lane, 0);
    check("reset_overrun", bus.overrun, 0);
    chk_en = 1'b1;

    // Level 0: four ticks, only the fourth moves.
    for (int t = 0; t < 4; t++) begin
      tick();
      wait_cycles(100);
      if (t < 3) check("lvl0_hold_lane0", car_lane(0), 0);
    end
    check("lvl0_lane0", car_lane(0), 1);
    check("lvl0_lane1", car_lane(1), 78);
    check("lvl0_lane2", car_lane(2), 163);

    // Asynchronous reset in the middle of a MOVE.
    bus.level = 4'd3;
    tick();
    wait_cycles(2);
    chk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) check("async_rst_car_x", car_lane(i), 80 * i);
    check("async_rst_hit", bus.hit, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_overrun", bus.overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    wait_cycles(2);

    // Frog on lane 0's car: CHECK-only frame, hit on cycle 9.
    bus.level = 4'd0;
    set_player(0, 64);
    tick();
    hit_t0 = t0;
    k = 0;
    while (!bus.hit && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("hit_cycle", cyc - hit_t0, 9);
    check("hit_lane_lit", bus.hit_lane, 0);
    @(negedge clk);
    check("hit_one_cycle", bus.hit, 0);
    check("busy_low_cycle10", bus.busy, 0);
    set_player(600, 0);
    wait_cycles(10);

    // Tick at cycle 0 and again at cycle 3: second one dropped, overrun sticks.
    tick();
    wait_cycles(1);
    tick();
    wait_cycles(30);
    check("overrun_set", bus.overrun, 1);
    check("overrun_no_move", car_lane(0), 0);
    tick();
    wait_cycles(30);
    tick();
    wait_cycles(30);
    check("overrun_one_move", car_lane(0), 1);
    check("overrun_sticky", bus.overrun, 1);

    // Level 9 saturates to period 1; run=0 freezes.
    bus.level = 4'd9;
    for (int t = 0; t < 2; t++) begin
      tick();
      wait_cycles(25);
    end
    check("lvl9_lane0", car_lane(0), 3);
    bus.run = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      wait_cycles(5);
    end
    check("frozen_lane0", car_lane(0), 3);
    bus.run = 1'b1;

    // Fresh start for wrap tests.
    chk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    bus.level = 4'd3;
    for (int t = 0; t < 41; t++) begin
      tick();
      wait_cycles(18);
    end
    check("wrap_lane1_41", car_lane(1), 638);
    check("lane0_41", car_lane(0), 41);
    for (int t = 41; t < 640; t++) begin
      tick();
      wait_cycles(18);
    end
    check("wrap_lane0_640", car_lane(0), 0);

    wait_cycles(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
